sram_line_arbiter: RTL and testbench

//  Upstream stage of the 128-bit SRAM controller. Arbitrates I-cache refill

---
 rtl/sram_line_arbiter_if.sv | 21 ++
 rtl/sram_line_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_line_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_line_arbiter_if.sv
// rtl/sram_line_arbiter_if.sv - controller-side bus of the SRAM line arbiter
// Purpose: bundles the single 128-bit SRAM controller port.
// Signals:
//   addr  [31:0]  word address, line aligned      (arbiter -> controller)
//   wdata [127:0] write line                      (arbiter -> controller)
//   wren          line write request              (arbiter -> controller)
//   rden          line read request               (arbiter -> controller)
//   rdata [127:0] read line, valid with ack       (controller -> arbiter)
//   ack           access complete                 (controller -> arbiter)
// Modports: master = arbiter side, slave = controller side.
interface sram_line_arbiter_if;
  logic [31:0]  addr;
  logic [127:0] wdata;
  logic         wren;
  logic         rden;
  logic [127:0] rdata;
  logic         ack;

  modport master (output addr, wdata, wren, rden, input rdata, ack);
  modport slave  (input addr, wdata, wren, rden, output rdata, ack);
endinterface

// File: rtl/sram_line_arbiter.sv
// rtl/sram_line_arbiter.sv - I/D-cache line arbiter in front of the 128-bit SRAM controller
// Purpose: grants one of the I-cache refill / D-cache refill-or-writeback
//   requests, converts the line byte address to a 16-bit SRAM word address,
//   holds the controller request stable and drops it in the ack cycle.
// Optional feature: SRAM_ARB_TIMEOUT_EN enables a BUSY watchdog that ends a
//   stalled access after TIMEOUT_CYCLES with err=1; without it err is 0.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   ic_req_i, ic_addr_i         I-cache line read request (level) and address
//   ic_rsp_valid_o, ic_rdata_o, ic_err_o   I-cache response pulse, line, error
//   dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i   D-cache request, write flag, addr, line
//   dc_rsp_valid_o, dc_rdata_o, dc_err_o   D-cache response pulse, line, error
//   mem                         controller port (sram_line_arbiter_if.master)
module sram_line_arbiter #(
  parameter int SRAM_AW        = 18,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ic_req_i,
  input  logic [31:0]                ic_addr_i,
  output logic                       ic_rsp_valid_o,
  output logic [127:0]               ic_rdata_o,
  output logic                       ic_err_o,
  input  logic                       dc_req_i,
  input  logic                       dc_we_i,
  input  logic [31:0]                dc_addr_i,
  input  logic [127:0]               dc_wdata_i,
  output logic                       dc_rsp_valid_o,
  output logic [127:0]               dc_rdata_o,
  output logic                       dc_err_o,
  sram_line_arbiter_if.master        mem
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q;
  logic          prio_q;   // 1: D-cache wins a tie
  logic          win_q;    // 1: current access belongs to the D-cache
  logic          we_q;
  logic [31:0]   addr_q;
  logic [127:0]  wdata_q;
  logic          ic_rsp_valid_q, dc_rsp_valid_q;
  logic [127:0]  ic_rdata_q, dc_rdata_q;

  logic          pick_dc;
  logic [31:0]   sel_addr;
  logic [31:0]   line_addr;
  logic          expired;
  logic          finish;
  logic [127:0]  line_in;

  assign pick_dc   = dc_req_i & (~ic_req_i | prio_q);
  assign sel_addr  = pick_dc ? dc_addr_i : ic_addr_i;
  // Line index moved down one bit (16-bit words), beat offset zeroed.
  assign line_addr = {{(32 - SRAM_AW){1'b0}}, sel_addr[SRAM_AW:4], 3'b000};

  assign finish    = (state_q == BUSY) & (mem.ack | expired);
  // Writes and timed-out accesses return an all-zero line.
  assign line_in   = (we_q | ~mem.ack) ? '0 : mem.rdata;

  // Request drops combinationally in the ack cycle so the controller never
  // sees it still high when it returns to idle.
  assign mem.rden  = (state_q == BUSY) & ~we_q & ~mem.ack & ~expired;
  assign mem.wren  = (state_q == BUSY) &  we_q & ~mem.ack & ~expired;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  assign ic_rsp_valid_o = ic_rsp_valid_q;
  assign dc_rsp_valid_o = dc_rsp_valid_q;
  assign ic_rdata_o     = ic_rdata_q;
  assign dc_rdata_o     = dc_rdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[31:SRAM_AW+1], sel_addr[3:0]};

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             ic_err_q, dc_err_q;

  // cnt_q is 0 in the first BUSY cycle, so the limit is hit in BUSY cycle
  // number TIMEOUT_CYCLES.
  assign expired = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic_err_q <= 1'b0;
      dc_err_q <= 1'b0;
    end else if (finish) begin
      if (win_q) dc_err_q <= ~mem.ack;
      else       ic_err_q <= ~mem.ack;
    end
  end

  assign ic_err_o = ic_err_q;
  assign dc_err_o = dc_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expired  = 1'b0;
  assign ic_err_o = 1'b0;
  assign dc_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      prio_q         <= 1'b0;
      win_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      ic_rsp_valid_q <= 1'b0;
      dc_rsp_valid_q <= 1'b0;
      ic_rdata_q     <= '0;
      dc_rdata_q     <= '0;
    end else begin
      ic_rsp_valid_q <= 1'b0;
      dc_rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ic_req_i || dc_req_i) begin
            win_q   <= pick_dc;
            we_q    <= pick_dc & dc_we_i;
            addr_q  <= line_addr;
            wdata_q <= pick_dc ? dc_wdata_i : '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            if (win_q) begin
              dc_rsp_valid_q <= 1'b1;
              dc_rdata_q     <= line_in;
            end else begin
              ic_rsp_valid_q <= 1'b1;
              ic_rdata_q     <= line_in;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          prio_q  <= ~win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_line_arbiter.sv
// tb/tb_sram_line_arbiter.sv - self-checking bench for sram_line_arbiter
module tb_sram_line_arbiter;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         ic_req = 1'b0;
  logic [31:0]  ic_addr = '0;
  logic         ic_rsp_valid;
  logic [127:0] ic_rdata;
  logic         ic_err;
  logic         dc_req = 1'b0;
  logic         dc_we = 1'b0;
  logic [31:0]  dc_addr = '0;
  logic [127:0] dc_wdata = '0;
  logic         dc_rsp_valid;
  logic [127:0] dc_rdata;
  logic         dc_err;

  sram_line_arbiter_if mif();

  sram_line_arbiter #(.SRAM_AW(18), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr),
    .ic_rsp_valid_o(ic_rsp_valid), .ic_rdata_o(ic_rdata), .ic_err_o(ic_err),
    .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_rsp_valid_o(dc_rsp_valid), .dc_rdata_o(dc_rdata), .dc_err_o(dc_err),
    .mem(mif)
  );

  // Controller model: 8 request cycles, then ack for one cycle.
  logic         stall = 1'b0;
  logic [127:0] model_line = '0;
  int           beats, launches, acks;
  logic         prev_req;

  assign mif.rdata = mif.ack ? model_line : ~model_line;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mif.ack  <= 1'b0;
      beats    <= 0;
      prev_req <= 1'b0;
    end else begin
      prev_req <= mif.rden | mif.wren;
      if ((mif.rden | mif.wren) && !prev_req) launches <= launches + 1;
      if (mif.ack) begin
        mif.ack <= 1'b0;
        beats   <= 0;
        acks    <= acks + 1;
      end else if (mif.rden | mif.wren) begin
        if (!stall && beats == 7) mif.ack <= 1'b1;
        beats <= beats + 1;
      end else begin
        beats <= 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk_bits(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  typedef struct {
    logic         dc;
    logic [127:0] rdata;
    logic         err;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (ic_rsp_valid || dc_rsp_valid)) begin
      if (ic_rsp_valid && dc_rsp_valid) begin
        checks++; errors++;
        $display("FAIL dual_rsp got both ic and dc rsp_valid");
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp ic=%0b dc=%0b", ic_rsp_valid, dc_rsp_valid);
      end else begin
        e = sb.pop_front();
        chk_bits("rsp_client", 128'(dc_rsp_valid), 128'(e.dc));
        chk_bits("rsp_rdata", dc_rsp_valid ? dc_rdata : ic_rdata, e.rdata);
        chk_bits("rsp_err", 128'(dc_rsp_valid ? dc_err : ic_err), 128'(e.err));
      end
    end
  end

  typedef struct {
    logic         dc;
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] line;
    logic [31:0]  maddr;
  } vec_t;
  vec_t vecs[7];

  task automatic do_access(input vec_t v, input bit scramble);
    int   rsp_at, first_req, nreq;
    bit   stable, overlap;
    exp_t e;
    @(negedge clk);
    model_line = v.line;
    if (v.dc) begin
      dc_req = 1'b1; dc_we = v.we; dc_addr = v.addr; dc_wdata = v.wdata;
    end else begin
      ic_req = 1'b1; ic_addr = v.addr;
    end
    e.dc = v.dc; e.rdata = v.we ? '0 : v.line; e.err = 1'b0;
    sb.push_back(e);
    rsp_at = -1; first_req = -1; nreq = 0; stable = 1'b1; overlap = 1'b0;
    for (int k = 1; k <= 40 && rsp_at < 0; k++) begin
      @(negedge clk);
      if (mif.rden | mif.wren) begin
        nreq++;
        if (first_req < 0) first_req = k;
        if (mif.addr != v.maddr || mif.wren != v.we || mif.rden == v.we) stable = 1'b0;
        if (v.we && mif.wdata != v.wdata) stable = 1'b0;
      end
      if (mif.ack && (mif.rden | mif.wren)) overlap = 1'b1;
      if (scramble && k == 3) begin
        dc_addr = ~v.addr; dc_wdata = ~v.wdata; dc_we = ~v.we;
      end
      if (v.dc ? dc_rsp_valid : ic_rsp_valid) rsp_at = k;
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    chk_int("rsp_latency", rsp_at, 10);
    chk_int("mem_req_start", first_req, 1);
    chk_int("mem_req_cycles", nreq, 8);
    chk_int("mem_req_stable", int'(stable), 1);
    chk_int("req_low_in_ack", int'(overlap), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    exp_t e;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1230, 128'h0, {16{8'hA5}}, 32'h0000_0918};
    vecs[1] = '{1'b1, 1'b1, 32'h0003_FFF0, 128'h0123456789ABCDEF0123456789ABCDEF, {16{8'h3C}}, 32'h0001_FFF8};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0000, 128'h0, 128'hDEADBEEF_00000001_CAFEF00D_12345678, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 128'h0, {8{16'h0F0F}}, 32'h0003_FFF8};
    vecs[4] = '{1'b1, 1'b0, 32'h0004_0010, 128'h0, 128'h1, 32'h0002_0008};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_1238, {8{16'hFF00}}, {16{8'h77}}, 32'h0000_0918};
    vecs[6] = '{1'b0, 1'b0, 32'h0008_000F, 128'h0, {4{32'h8000_0001}}, 32'h0000_0000};

    launches = 0; acks = 0;
    repeat (3) @(negedge clk);
    chk_bits("reset_outputs",
             {ic_rsp_valid, dc_rsp_valid, ic_err, dc_err, mif.rden, mif.wren, mif.addr, 90'h0},
             128'h0);
    chk_bits("reset_lines", ic_rdata | dc_rdata | mif.wdata, 128'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_access(vecs[i], 1'b0);

    // D-cache inputs changed mid-access must not reach the controller.
    do_access(vecs[1], 1'b1);
    chk_bits("ic_rdata_hold", ic_rdata, vecs[6].line);
    do_access(vecs[0], 1'b0);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    model_line = {16{8'hA5}};
    ic_addr = 32'h0000_1230; ic_req = 1'b1;
    e.dc = 1'b0; e.rdata = model_line; e.err = 1'b0;
    sb.push_back(e);
    repeat (4) @(negedge clk);
    chk_bits("rden_before_reset", 128'(mif.rden), 128'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_bits("async_reset_ctl",
             {ic_rsp_valid, dc_rsp_valid, ic_err, dc_err, mif.rden, mif.wren, mif.addr, 90'h0},
             128'h0);
    chk_bits("async_reset_lines", ic_rdata | dc_rdata | mif.wdata, 128'h0);
    ic_req = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Both clients requesting: strict alternation starting with the I-cache.
    begin : both
      int n, l0, a0;
      int t[4];
      bit ic_up, dc_up;
      model_line = {8{16'h5AA5}};
      ic_addr = 32'h0000_0100; dc_addr = 32'h0000_0200; dc_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
        e.dc = 1'(i % 2); e.rdata = model_line; e.err = 1'b0;
        sb.push_back(e);
        t[i] = -1;
      end
      l0 = launches; a0 = acks; n = 0; ic_up = 1'b0; dc_up = 1'b0;
      @(negedge clk);
      ic_req = 1'b1; dc_req = 1'b1;
      for (int k = 1; k <= 100 && n < 4; k++) begin
        @(negedge clk);
        if (ic_up) begin ic_req = 1'b1; ic_up = 1'b0; end
        if (dc_up) begin dc_req = 1'b1; dc_up = 1'b0; end
        if (ic_rsp_valid && n < 4) begin t[n] = k; n++; ic_req = 1'b0; ic_up = (n <= 2); end
        if (dc_rsp_valid && n < 4) begin t[n] = k; n++; dc_req = 1'b0; dc_up = (n <= 2); end
      end
      ic_req = 1'b0; dc_req = 1'b0;
      @(negedge clk);
      chk_int("both_count", n, 4);
      chk_int("both_first_latency", t[0], 10);
      chk_int("both_gap1", t[1] - t[0], 11);
      chk_int("both_gap2", t[2] - t[1], 11);
      chk_int("both_gap3", t[3] - t[2], 11);
      chk_int("both_launches", launches - l0, 4);
      chk_int("both_acks", acks - a0, 4);
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    begin : stall_t
      int rsp_at;
      bit late;
      stall = 1'b1;
      model_line = {16{8'hC3}};
      e.dc = 1'b1; e.rdata = '0; e.err = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0040;
      rsp_at = -1; late = 1'b0;
      for (int k = 1; k <= TMO + 20 && rsp_at < 0; k++) begin
        @(negedge clk);
        if (k >= TMO + 1 && (mif.rden | mif.wren)) late = 1'b1;
        if (dc_rsp_valid) rsp_at = k;
      end
      dc_req = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (mif.rden | mif.wren) late = 1'b1;
      end
      stall = 1'b0;
      chk_int("timeout_latency", rsp_at, TMO + 1);
      chk_int("timeout_req_low", int'(late), 0);
      chk_bits("timeout_err_hold", 128'(dc_err), 128'h1);
      do_access(vecs[2], 1'b0);
      chk_bits("err_clears", 128'(dc_err), 128'h0);
    end
`endif

    repeat (2) @(negedge clk);
    chk_int("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
